// File: rtl/sw_out_arb_if.sv
// Handshake bundle between the requesters of one switch output port and its arbiter.
interface sw_out_arb_if #(
  parameter int IN_N  = 5,
  parameter int IDX_W = $clog2(IN_N)
);
  logic [IN_N-1:0]  req_i;
  logic [IN_N-1:0]  last_i;
  logic             dnrdy_i;
  logic [IN_N-1:0]  gnt_o;
  logic [IDX_W-1:0] gnt_idx_o;
  logic [IN_N-1:0]  uprdy_o;
  logic             dnreq_o;
  logic             busy_o;

  modport master (
    output req_i, last_i, dnrdy_i,
    input  gnt_o, gnt_idx_o, uprdy_o, dnreq_o, busy_o
  );

  modport slave (
    input  req_i, last_i, dnrdy_i,
    output gnt_o, gnt_idx_o, uprdy_o, dnreq_o, busy_o
  );
endinterface

// File: rtl/sw_out_arb.sv
// Round-robin output-port arbiter; packet locking (hold grant until last beat)
// is enabled by defining SW_ARB_LOCK_EN.
module sw_out_arb #(
  parameter int IN_N  = 5,
  parameter int IDX_W = $clog2(IN_N)
) (
  input logic          clk,
  input logic          rst_n,
  sw_out_arb_if.slave  bus
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W:0]   k;
  logic             sel_vld;
  logic             lock;
  logic             fire;
  logic [IN_N-1:0]  gnt;
  logic [IN_N-1:0]  gnt_req;

  // Rotating search from ptr; one extra bit keeps ptr+i from aliasing before the wrap.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    k       = '0;
    for (int unsigned i = 0; i < IN_N; i++) begin
      k = {1'b0, ptr} + (IDX_W+1)'(i);
      if (k >= (IDX_W+1)'(IN_N)) k = k - (IDX_W+1)'(IN_N);
      if (!sel_vld && bus.req_i[k[IDX_W-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = k[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (lock || sel_vld) gnt[gidx] = 1'b1;
  end

  assign gnt_req       = gnt & bus.req_i;
  assign fire          = (|gnt_req) & bus.dnrdy_i;
  assign nxt_ptr       = (gidx == IDX_W'(IN_N-1)) ? '0 : gidx + 1'b1;

  assign bus.gnt_o     = gnt;
  assign bus.gnt_idx_o = gidx;
  assign bus.uprdy_o   = gnt_req & {IN_N{bus.dnrdy_i}};
  assign bus.dnreq_o   = |gnt_req;
  assign bus.busy_o    = lock;

`ifdef SW_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCK} state_t;
  state_t           state;
  logic [IDX_W-1:0] owner;

  assign lock = (state == LOCK);
  assign gidx = lock ? owner : sel_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else if (fire) begin
      case (state)
        IDLE: begin
          if (bus.last_i[gidx]) begin
            ptr <= nxt_ptr;
          end else begin
            state <= LOCK;
            owner <= gidx;
          end
        end
        LOCK: begin
          if (bus.last_i[owner]) begin
            state <= IDLE;
            ptr   <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_last;

  assign unused_last = ^bus.last_i;
  assign lock        = 1'b0;
  assign gidx        = sel_idx;

  // Every fired beat is a whole packet, so the pointer always advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= '0;
    else if (fire) ptr <= nxt_ptr;
  end
`endif

endmodule

// File: tb/tb_sw_out_arb.sv
// Randomized and directed bench for sw_out_arb (IN_N=4) against a packet-level
// reference model; explicit constants follow the SW_ARB_LOCK_EN build setting.
module tb_sw_out_arb;
  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sw_out_arb_if #(.IN_N(N), .IDX_W(W)) bus ();

  sw_out_arb #(.IN_N(N), .IDX_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [11:0] obs;
  assign obs = {bus.gnt_o, bus.gnt_idx_o, bus.uprdy_o, bus.dnreq_o, bus.busy_o};

  // Reference model: packet-level view of the port.
  bit m_lock;
  int m_ptr;
  int m_owner;

  function automatic int exp_g();
    if (m_lock) return m_owner;
    for (int i = 0; i < N; i++)
      if (bus.req_i[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  function automatic logic [11:0] model_out();
    int g;
    logic [N-1:0] gv;
    logic [W-1:0] gi;
    logic dn;
    g  = exp_g();
    gv = (g >= 0) ? (N'(1) << g) : '0;
    gi = (g >= 0) ? W'(g) : '0;
    dn = (g >= 0) && bus.req_i[g];
    return {gv, gi, (dn && bus.dnrdy_i) ? gv : 4'b0000, dn, m_lock};
  endfunction

  task automatic model_reset();
    m_lock = 0; m_ptr = 0; m_owner = 0;
  endtask

  task automatic tick();
    int g;
    bit f;
    g = exp_g();
    f = (g >= 0) && bus.req_i[g] && bus.dnrdy_i;
    if (rst_n && f) begin
`ifdef SW_ARB_LOCK_EN
      if (!m_lock) begin
        if (bus.last_i[g]) m_ptr = (g + 1) % N;
        else begin m_lock = 1; m_owner = g; end
      end else if (bus.last_i[m_owner]) begin
        m_lock = 0; m_ptr = (m_owner + 1) % N;
      end
`else
      m_ptr = (g + 1) % N;
`endif
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic d);
    bus.req_i = r; bus.last_i = l; bus.dnrdy_i = d;
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    drive('0, '0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(4'b0000, 4'b0000, 1'b1);
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL reset_idle obs=%h exp=%h", obs, 12'h000); end
    drive(4'b0110, 4'b1111, 1'b1);
    checks++;
    if (obs !== model_out()) begin errors++; $display("FAIL reset_req obs=%h exp=%h", obs, model_out()); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.gnt_o !== 4'b0000) begin
      errors++; $display("FAIL reset_release busy=%b gnt=%b exp busy=0 gnt=0000", bus.busy_o, bus.gnt_o);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [3] = '{4'b0010, 4'b1000, 4'b0010};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1010, 4'b1111, 1'b1);
      checks++;
      if (bus.gnt_o !== exp_seq[i] || obs !== model_out()) begin
        errors++; $display("FAIL round_robin[%0d] gnt=%b exp=%b obs=%h model=%h", i, bus.gnt_o, exp_seq[i], obs, model_out());
      end
      tick();
    end
  endtask

  task automatic test_lock();
    logic [N-1:0] l;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      l = (i == 3) ? 4'b0001 : 4'b0000;
      drive(4'b0011, l, 1'b1);
      checks++;
      if (obs !== model_out()) begin errors++; $display("FAIL lock_model[%0d] obs=%h exp=%h", i, obs, model_out()); end
`ifdef SW_ARB_LOCK_EN
      checks++;
      if (bus.gnt_o !== ((i < 4) ? 4'b0001 : 4'b0010) || bus.busy_o !== (i >= 1 && i <= 3)) begin
        errors++; $display("FAIL lock_seq[%0d] gnt=%b busy=%b", i, bus.gnt_o, bus.busy_o);
      end
`endif
      tick();
    end
  endtask

  task automatic test_lock_hold();
    do_reset();
    drive(4'b0001, 4'b0000, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(4'b0010, 4'b0000, 1'b1);
      checks++;
      if (obs !== model_out()) begin errors++; $display("FAIL lock_hold_model[%0d] obs=%h exp=%h", i, obs, model_out()); end
`ifdef SW_ARB_LOCK_EN
      checks++;
      if (bus.gnt_o !== 4'b0001 || bus.dnreq_o !== 1'b0 || bus.uprdy_o !== 4'b0000 || bus.busy_o !== 1'b1) begin
        errors++; $display("FAIL lock_hold[%0d] gnt=%b dnreq=%b uprdy=%b busy=%b exp 0001 0 0000 1",
                           i, bus.gnt_o, bus.dnreq_o, bus.uprdy_o, bus.busy_o);
      end
`endif
      tick();
    end
    drive(4'b0001, 4'b0001, 1'b1);
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1001, 4'b1111, 1'b0);
      checks++;
      if (obs !== model_out() || bus.gnt_o !== 4'b0001 || bus.dnreq_o !== 1'b1 || bus.uprdy_o !== 4'b0000) begin
        errors++; $display("FAIL stall[%0d] obs=%h exp=%h", i, obs, model_out());
      end
      tick();
    end
    drive(4'b1001, 4'b1111, 1'b1);
    checks++;
    if (bus.uprdy_o !== 4'b0001) begin errors++; $display("FAIL stall_fire uprdy=%b exp=0001", bus.uprdy_o); end
    tick();
    drive(4'b1001, 4'b1111, 1'b0);
    checks++;
    if (bus.gnt_o !== 4'b1000 || bus.gnt_idx_o !== 2'd3) begin
      errors++; $display("FAIL stall_next gnt=%b idx=%0d exp=1000 idx=3", bus.gnt_o, bus.gnt_idx_o);
    end
  endtask

  task automatic test_reset_in_lock();
    do_reset();
    drive(4'b1000, 4'b0000, 1'b1);
    tick();
    drive(4'b0001, 4'b0000, 1'b1);
    checks++;
    if (obs !== model_out()) begin errors++; $display("FAIL pre_abort obs=%h exp=%h", obs, model_out()); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || obs !== model_out()) begin
      errors++; $display("FAIL abort busy=%b obs=%h exp=%h", bus.busy_o, obs, model_out());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(4'b1000, 4'b0000, 1'b0);
    checks++;
    if (bus.gnt_o !== 4'b1000 || bus.gnt_idx_o !== 2'd3 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL post_abort gnt=%b idx=%0d busy=%b exp 1000 3 0", bus.gnt_o, bus.gnt_idx_o, bus.busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_seq [3] = '{4'b0001, 4'b0010, 4'b0001};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, 4'b0000, 1'b1);
      checks++;
      if (obs !== model_out()) begin errors++; $display("FAIL b2b_model[%0d] obs=%h exp=%h", i, obs, model_out()); end
`ifndef SW_ARB_LOCK_EN
      checks++;
      if (bus.gnt_o !== exp_seq[i] || bus.busy_o !== 1'b0) begin
        errors++; $display("FAIL b2b[%0d] gnt=%b exp=%b busy=%b", i, bus.gnt_o, exp_seq[i], bus.busy_o);
      end
`else
      if (i == 0 && exp_seq[0] !== bus.gnt_o) begin
        errors++; $display("FAIL b2b_first gnt=%b exp=%b", bus.gnt_o, exp_seq[0]);
      end
`endif
      tick();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r, l;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = N'($urandom);
      l = N'($urandom) | N'($urandom);
      drive(r, l, ($urandom_range(0, 3) != 0));
      checks++;
      if (obs !== model_out() || $countones(bus.gnt_o) > 1) begin
        errors++; $display("FAIL random[%0d] req=%b last=%b rdy=%b obs=%h exp=%h",
                           i, r, l, bus.dnrdy_i, obs, model_out());
      end
      tick();
    end
  endtask

  initial begin
    bus.req_i = '0; bus.last_i = '0; bus.dnrdy_i = 1'b0;
    test_reset();
    test_round_robin();
    test_lock();
    test_lock_hold();
    test_stall();
    test_reset_in_lock();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sw_out_arb.md
SW_OUT_ARB -- requirements
Module: sw_out_arb

Interface
REQ-001 The block SHALL expose parameter IN_N, default 5, giving the number of upstream requesters sharing one switch output port (2..16).
REQ-002 The block SHALL expose parameter IDX_W, default $clog2(IN_N), giving the grant-index width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_i  input  IN_N  per-requester valid toward this output port.
REQ-006 last_i  input  IN_N  per-requester final-beat flag, qualified by req_i.
REQ-007 dnrdy_i  input  1  downstream ready of the output port.
REQ-008 gnt_o  output  IN_N  one-hot (or zero) grant selecting the tag mux.
REQ-009 gnt_idx_o  output  IDX_W  binary index of gnt_o; 0 when gnt_o is zero.
REQ-010 uprdy_o  output  IN_N  per-requester ready, equal to gnt_o & req_i replicated with dnrdy_i.
REQ-011 dnreq_o  output  1  downstream valid, equal to OR of (gnt_o & req_i).
REQ-012 busy_o  output  1  high while in state LOCK.

Function
REQ-013 A beat SHALL fire in a cycle when dnreq_o and dnrdy_i are both 1; the fired requester g is the set bit of gnt_o.
REQ-014 The block SHALL have two states: IDLE and LOCK, plus registers ptr (IDX_W), owner (IDX_W).
REQ-015 In IDLE, gnt_o SHALL combinationally select the first requester with req_i set, searching from index ptr upward with wrap IN_N-1 -> 0; gnt_o SHALL be zero if req_i is zero.
REQ-016 In LOCK, gnt_o SHALL be one-hot at owner regardless of req_i; if req_i[owner] is 0, dnreq_o SHALL be 0 and no other requester is granted.
REQ-017 IDLE, fire with last_i[g]=1: stay IDLE, ptr <= g+1 modulo IN_N.
REQ-018 IDLE, fire with last_i[g]=0: go LOCK, owner <= g, ptr unchanged.
REQ-019 LOCK, fire with last_i[owner]=1: go IDLE, ptr <= owner+1 modulo IN_N.
REQ-020 LOCK, fire with last_i[owner]=0, or no fire: stay LOCK.
REQ-021 No fire in IDLE SHALL leave ptr and state unchanged; the grant MAY change with req_i (no hold without fire).
REQ-022 The ptr wrap SHALL be explicit: g = IN_N-1 yields ptr = 0 for non-power-of-two IN_N.
REQ-023 Grant decision, uprdy_o and dnreq_o SHALL be combinational from inputs and state (zero-cycle latency); state updates SHALL take effect the following cycle.

Reset
REQ-024 While rst_n is 0: state SHALL be IDLE, ptr 0, owner 0, busy_o 0.
REQ-025 Out of reset, outputs SHALL follow REQ-015 from ptr=0: with req_i=0, gnt_o=0, gnt_idx_o=0, uprdy_o=0, dnreq_o=0.
REQ-026 Reset asserted mid-packet in LOCK SHALL abandon the packet with no further grant to owner forced.

Configuration
REQ-027 Macro SW_ARB_LOCK_EN SHALL control packet locking.
REQ-028 With SW_ARB_LOCK_EN defined, behaviour SHALL be as REQ-014..REQ-026.
REQ-029 Without SW_ARB_LOCK_EN, last_i SHALL be ignored, every fired beat SHALL be treated as last (REQ-017), LOCK SHALL never be entered, busy_o SHALL be constant 0 and owner SHALL be removed.

Verification (IN_N=4, SW_ARB_LOCK_EN defined unless stated)
REQ-030 After reset, req_i=4'b1010, last_i=4'b1111, dnrdy_i=1 -> gnt_o=0010 fires; next cycle ptr=2, gnt_o=1000; then ptr=0, gnt_o=0010 (round-robin).
REQ-031 req_i=4'b0011, last_i[0]=0 for 3 beats then 1, dnrdy_i=1 -> gnt_o=0001 for 4 beats, busy_o high beats 2-4 cycles, req 1 not granted until after last beat, then gnt_o=0010.
REQ-032 In LOCK owner=0, req_i drops to 4'b0010 for 2 cycles -> gnt_o stays 0001, dnreq_o=0, uprdy_o=0000; state stays LOCK.
REQ-033 req_i=4'b1001, dnrdy_i=0 for 5 cycles -> gnt_o=0001, dnreq_o=1, uprdy_o=0, ptr unchanged; on dnrdy_i=1 with last -> ptr=1, next grant 1000.
REQ-034 Assert rst_n=0 in LOCK owner=3 -> busy_o=0 immediately, ptr=0; after release req_i=4'b1000 -> gnt_o=1000, gnt_idx_o=3.
REQ-035 Macro undefined, req_i=4'b0011, last_i=0 -> grants alternate 0001,0010,0001 each beat; busy_o always 0.
